// File: rtl/alu_op_sequencer.sv
// Issue stage in front of the combinational ALU. It holds the operands for an opcode-dependent
// settle time, captures a 64-bit HI/LO response and offers it on a valid/ready handshake.
module alu_op_sequencer #(
    parameter int unsigned BASIC_CYCLES = 1,
    parameter int unsigned MUL_CYCLES   = 4,
    parameter int unsigned DIV_CYCLES   = 8
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_result_hi,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        rsp_illegal,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_DIV  = 4'h7;
    localparam logic [3:0] OP_REM  = 4'h8;
    localparam logic [3:0] OP_LAST = 4'hD;

    // The counter is loaded with N-1 so that the capture edge is the N-th edge after accept.
    localparam logic [7:0] BASIC_LOAD = 8'(BASIC_CYCLES - 1);
    localparam logic [7:0] MUL_LOAD   = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD   = 8'(DIV_CYCLES - 1);

    function automatic logic [7:0] exec_load(input logic [3:0] op);
        logic [7:0] load;
        if (op == OP_MUL) begin
            load = MUL_LOAD;
        end else if (op == OP_DIV || op == OP_REM) begin
            load = DIV_LOAD;
        end else begin
            load = BASIC_LOAD;
        end
        return load;
    endfunction

    state_e      state_q,        state_d;
    logic [7:0]  cnt_q,          cnt_d;
    logic [31:0] alu_a_q,        alu_a_d;
    logic [31:0] alu_b_q,        alu_b_d;
    logic [3:0]  alu_opcode_q,   alu_opcode_d;
    logic [31:0] rsp_lo_q,       rsp_lo_d;
    logic [31:0] rsp_hi_q,       rsp_hi_d;
    logic        rsp_carry_q,    rsp_carry_d;
    logic        rsp_overflow_q, rsp_overflow_d;
    logic        rsp_illegal_q,  rsp_illegal_d;
    logic        rsp_valid_q,    rsp_valid_d;
    logic        req_ready_q,    req_ready_d;
    logic        busy_q,         busy_d;

    logic        keep_hi;
    logic        keep_flags;

    assign keep_hi    = (alu_opcode_q == OP_MUL) || (alu_opcode_q == OP_DIV);
    assign keep_flags = (alu_opcode_q == OP_ADD) || (alu_opcode_q == OP_SUB);

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through the case below infers a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_opcode_d   = alu_opcode_q;
        rsp_lo_d       = rsp_lo_q;
        rsp_hi_d       = rsp_hi_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_illegal_d  = rsp_illegal_q;
        rsp_valid_d    = rsp_valid_q;
        req_ready_d    = req_ready_q;
        busy_d         = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_a_d      = req_a;
                    alu_b_d      = req_b;
                    alu_opcode_d = req_opcode;
                    req_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    if (req_opcode <= OP_LAST) begin
                        cnt_d   = exec_load(req_opcode);
                        state_d = ST_EXEC;
                    end else begin
                        // Unsupported opcodes skip the ALU entirely and answer at once.
                        rsp_lo_d       = '0;
                        rsp_hi_d       = '0;
                        rsp_carry_d    = 1'b0;
                        rsp_overflow_d = 1'b0;
                        rsp_illegal_d  = 1'b1;
                        rsp_valid_d    = 1'b1;
                        state_d        = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == 8'd0) begin
                    rsp_lo_d       = alu_result;
                    rsp_hi_d       = keep_hi ? alu_result_hi : 32'd0;
                    rsp_carry_d    = keep_flags & alu_carry;
                    rsp_overflow_d = keep_flags & alu_overflow;
                    rsp_illegal_d  = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_opcode_q   <= '0;
            rsp_lo_q       <= '0;
            rsp_hi_q       <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_illegal_q  <= 1'b0;
            rsp_valid_q    <= 1'b0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_opcode_q   <= alu_opcode_d;
            rsp_lo_q       <= rsp_lo_d;
            rsp_hi_q       <= rsp_hi_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_illegal_q  <= rsp_illegal_d;
            rsp_valid_q    <= rsp_valid_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_opcode   = alu_opcode_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_lo       = rsp_lo_q;
    assign rsp_hi       = rsp_hi_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_illegal  = rsp_illegal_q;
    assign busy         = busy_q;

endmodule
